// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encodings and baud helper for the UART command receiver
package uart_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         PKT_LEN   = 5;

  typedef enum logic [2:0] {
    BE_IDLE,
    BE_START,
    BE_DATA,
    BE_STOP,
    BE_WAIT_HIGH
  } bit_state_t;

  typedef enum logic [2:0] {
    P_WAIT_SYNC,
    P_GET_ADDR,
    P_GET_HI,
    P_GET_LO,
    P_GET_CHK
  } parse_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - rx synchroniser and 8N1 bit engine producing byte and frame-error pulses
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       err_frame,
  output logic       busy
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);

  logic             rx_meta;
  logic             rx_s;
  bit_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             expire;

  assign expire = (cnt <= CNT_W'(1));
  assign busy   = (state != BE_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BE_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      err_frame  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      err_frame  <= 1'b0;
      if (!expire) cnt <= cnt - CNT_W'(1);
      case (state)
        BE_IDLE: begin
          if (!rx_s) begin
            state <= BE_START;
            cnt   <= CNT_HALF;
          end
        end
        BE_START: begin
          // a start bit that is gone by mid-bit was line noise
          if (expire) begin
            if (rx_s) begin
              state <= BE_IDLE;
            end else begin
              state   <= BE_DATA;
              cnt     <= CNT_FULL;
              bit_idx <= '0;
            end
          end
        end
        BE_DATA: begin
          if (expire) begin
            shreg   <= {rx_s, shreg[7:1]};
            cnt     <= CNT_FULL;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= BE_STOP;
          end
        end
        BE_STOP: begin
          if (expire) begin
            if (rx_s) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
              state      <= BE_IDLE;
            end else begin
              err_frame <= 1'b1;
              state     <= BE_WAIT_HIGH;
            end
          end
        end
        BE_WAIT_HIGH: begin
          if (rx_s) state <= BE_IDLE;
        end
        default: state <= BE_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_receiver.sv
// rtl/uart_cmd_receiver.sv - frames UART bytes into checksummed 5-byte register-write commands
module uart_cmd_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        cmd_valid,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        err_frame,
  output logic        err_chksum,
  output logic        rx_activity
);

  localparam int              CPB      = clks_per_bit(CLK_FREQ, BAUD);
  localparam int              TO_LIMIT = TIMEOUT_BITS * CPB;
  localparam int              TO_W     = $clog2(TO_LIMIT + 1);
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TO_LIMIT);

  logic            byte_valid;
  logic [7:0]      byte_data;
  logic            frame_err;
  parse_state_t    pstate;
  logic [7:0]      addr_r;
  logic [7:0]      hi_r;
  logic [7:0]      lo_r;
  logic [TO_W-1:0] to_cnt;
  logic            timeout;

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB)
  ) u_rx_byte (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .err_frame  (frame_err),
    .busy       (rx_activity)
  );

  assign err_frame = frame_err;
  assign timeout   = (pstate != P_WAIT_SYNC) && (to_cnt == TO_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstate     <= P_WAIT_SYNC;
      addr_r     <= '0;
      hi_r       <= '0;
      lo_r       <= '0;
      to_cnt     <= '0;
      cmd_valid  <= 1'b0;
      cmd_addr   <= '0;
      cmd_data   <= '0;
      err_chksum <= 1'b0;
    end else begin
      cmd_valid  <= 1'b0;
      err_chksum <= 1'b0;
      // inter-byte silence counter, saturating so a stalled packet stays aborted
      if (byte_valid || pstate == P_WAIT_SYNC) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      if (frame_err || timeout) begin
        pstate <= P_WAIT_SYNC;
      end else if (byte_valid) begin
        case (pstate)
          P_WAIT_SYNC: if (byte_data == SYNC_BYTE) pstate <= P_GET_ADDR;
          P_GET_ADDR: begin
            addr_r <= byte_data;
            pstate <= P_GET_HI;
          end
          P_GET_HI: begin
            hi_r   <= byte_data;
            pstate <= P_GET_LO;
          end
          P_GET_LO: begin
            lo_r   <= byte_data;
            pstate <= P_GET_CHK;
          end
          P_GET_CHK: begin
            if (byte_data == (addr_r ^ hi_r ^ lo_r)) begin
              cmd_valid <= 1'b1;
              cmd_addr  <= addr_r;
              cmd_data  <= {hi_r, lo_r};
            end else begin
              err_chksum <= 1'b1;
            end
            pstate <= P_WAIT_SYNC;
          end
          default: pstate <= P_WAIT_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_receiver.sv
// tb/tb_uart_cmd_receiver.sv - self-checking bench for uart_cmd_receiver
module tb_uart_cmd_receiver;
  import uart_pkg::*;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        cmd_valid;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        err_frame;
  logic        err_chksum;
  logic        rx_activity;

  uart_cmd_receiver #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD         (BAUD),
    .TIMEOUT_BITS (40)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .cmd_valid   (cmd_valid),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .err_frame   (err_frame),
    .err_chksum  (err_chksum),
    .rx_activity (rx_activity)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0, n_chk = 0, n_frm = 0, n_overlap = 0;
  int last_valid_cyc = 0, start_cyc = 0;
  logic act_seen = 1'b0;
  logic [23:0] got_q[$];

  always @(negedge clk) begin
    if (cmd_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
      got_q.push_back({cmd_addr, cmd_data});
    end
    if (err_chksum) n_chk++;
    if (err_frame) n_frm++;
    if (cmd_valid && (err_chksum || err_frame)) n_overlap++;
    if (rx_activity) act_seen = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      if (i == 0) start_cyc = cyc;
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pkt(input logic [39:0] p);
    for (int i = 0; i < PKT_LEN; i++) send_byte(p[39-8*i -: 8]);
  endtask

  typedef struct {
    logic [39:0] pkt;
    logic        ok;
    logic [7:0]  addr;
    logic [15:0] data;
  } vec_t;

  vec_t vecs[5];
  int v0, c0, f0, lat, nb, gap, i;
  logic [7:0] stream[$];
  logic [23:0] exp_q[$];
  int exp_bad;
  logic [7:0] a, h, l, c;

  task automatic snap();
    v0 = n_valid; c0 = n_chk; f0 = n_frm;
  endtask

  initial begin
    vecs[0] = '{40'hA5_10_12_34_36, 1'b1, 8'h10, 16'h1234};
    vecs[1] = '{40'hA5_10_12_34_00, 1'b0, 8'h10, 16'h1234};
    vecs[2] = '{40'hA5_20_00_FF_DF, 1'b1, 8'h20, 16'h00FF};
    vecs[3] = '{40'hA5_FF_00_00_FF, 1'b1, 8'hFF, 16'h0000};
    vecs[4] = '{40'hA5_00_00_00_00, 1'b1, 8'h00, 16'h0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset cmd_valid", cmd_valid, 0);
    check("reset cmd_addr", cmd_addr, 0);
    check("reset cmd_data", cmd_data, 0);
    check("reset err_frame", err_frame, 0);
    check("reset err_chksum", err_chksum, 0);
    check("reset rx_activity", rx_activity, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_bits(1);

    for (int v = 0; v < 5; v++) begin
      snap();
      send_pkt(vecs[v].pkt);
      idle_bits(2);
      check($sformatf("vec%0d valid_count", v), n_valid - v0, vecs[v].ok ? 1 : 0);
      check($sformatf("vec%0d chksum_count", v), n_chk - c0, vecs[v].ok ? 0 : 1);
      check($sformatf("vec%0d frame_count", v), n_frm - f0, 0);
      check($sformatf("vec%0d cmd_addr", v), cmd_addr, vecs[v].addr);
      check($sformatf("vec%0d cmd_data", v), cmd_data, vecs[v].data);
      if (vecs[v].ok) begin
        lat = last_valid_cyc - start_cyc;
        check($sformatf("vec%0d latency_in_95_102 (lat=%0d)", v, lat), (lat >= 95 && lat <= 102), 1);
      end
    end

    // junk before sync, A5 as the address byte
    snap();
    got_q.delete();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h55);
    send_pkt(40'hA5_A5_01_02_A6);
    idle_bits(2);
    check("junk valid_count", n_valid - v0, 1);
    check("junk chksum_count", n_chk - c0, 0);
    check("junk cmd_addr", cmd_addr, 8'hA5);
    check("junk cmd_data", cmd_data, 16'h0102);

    // stop bit low in DATA_HI with the line held low afterwards
    snap();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h12, 1'b0);
    rx = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("break frame_count", n_frm - f0, 1);
    check("break rx_activity_held", rx_activity, 1);
    @(posedge clk); #1;
    rx = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("break rx_activity_released", rx_activity, 0);
    @(posedge clk); #1;
    idle_bits(1);
    send_pkt(40'hA5_10_12_34_36);
    idle_bits(2);
    check("after_break valid_count", n_valid - v0, 1);
    check("after_break frame_count", n_frm - f0, 1);
    check("after_break cmd_data", cmd_data, 16'h1234);

    // short low glitch between bytes of a packet
    snap();
    send_byte(8'hA5); send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    act_seen = 1'b0;
    rx = 1'b0;
    repeat (3) @(posedge clk); #1;
    rx = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("glitch activity_seen", act_seen, 1);
    check("glitch engine_idle", rx_activity, 0);
    @(posedge clk); #1;
    send_byte(8'h77);
    idle_bits(2);
    check("glitch valid_count", n_valid - v0, 1);
    check("glitch chksum_count", n_chk - c0, 0);
    check("glitch frame_count", n_frm - f0, 0);
    check("glitch cmd_addr", cmd_addr, 8'h44);
    check("glitch cmd_data", cmd_data, 16'h5566);

    // inter-byte timeout
    snap();
    send_byte(8'hA5); send_byte(8'h10);
    idle_bits(40);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h36);
    idle_bits(2);
    check("timeout valid_count", n_valid - v0, 0);
    check("timeout chksum_count", n_chk - c0, 0);
    check("timeout frame_count", n_frm - f0, 0);

    // reset in the middle of a byte of a packet
    snap();
    send_byte(8'hA5); send_byte(8'h10);
    rx = 1'b0;
    repeat (35) @(posedge clk); #1;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst cmd_addr", cmd_addr, 0);
    check("midrst cmd_data", cmd_data, 0);
    check("midrst rx_activity", rx_activity, 0);
    check("midrst cmd_valid", cmd_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_bits(3);
    check("midrst no_partial", (n_valid - v0) + (n_chk - c0) + (n_frm - f0), 0);
    send_pkt(40'hA5_30_AB_CD_56);
    idle_bits(2);
    check("midrst valid_count", n_valid - v0, 1);
    check("midrst cmd_addr_after", cmd_addr, 8'h30);
    check("midrst cmd_data_after", cmd_data, 16'hABCD);

    // randomized packet stream against a byte-stream reference
    stream.delete();
    exp_q.delete();
    exp_bad = 0;
    for (int p = 0; p < 12; p++) begin
      nb = $urandom_range(0, 2);
      for (int j = 0; j < nb; j++) stream.push_back(8'($urandom));
      a = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
      c = a ^ h ^ l;
      if ($urandom_range(0, 2) == 0) c = c ^ 8'($urandom_range(1, 255));
      stream.push_back(SYNC_BYTE);
      stream.push_back(a); stream.push_back(h); stream.push_back(l); stream.push_back(c);
    end
    i = 0;
    while (i < stream.size()) begin
      if (stream[i] != SYNC_BYTE || i + PKT_LEN > stream.size()) begin
        i++;
      end else begin
        if ((stream[i+1] ^ stream[i+2] ^ stream[i+3]) == stream[i+4])
          exp_q.push_back({stream[i+1], stream[i+2], stream[i+3]});
        else
          exp_bad++;
        i += PKT_LEN;
      end
    end
    snap();
    got_q.delete();
    foreach (stream[k]) begin
      send_byte(stream[k]);
      gap = $urandom_range(0, 2);
      if (gap != 0) idle_bits(gap);
    end
    idle_bits(45);
    check("rand valid_count", got_q.size(), exp_q.size());
    check("rand chksum_count", n_chk - c0, exp_bad);
    check("rand frame_count", n_frm - f0, 0);
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("rand cmd%0d addr_data", k), got_q[k], exp_q[k]);

    check("no_error_overlap", n_overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
